// File: rtl/pmod_nic100_spi_arbiter.sv
// Two-requester round-robin arbiter feeding a shared SPI byte engine (opcode, writes, reads).
// Latency: grant one cycle after req; opcode offered on the grant edge; GAP_CYCLES idle plus a done cycle after the last byte.
// Backpressure: each write byte is held on eng_wr_valid until eng_wr_got_byte; the next byte waits for eng_wr_done.
module pmod_nic100_spi_arbiter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic [7:0] r0_op,
  input  logic [3:0] r0_nwr,
  input  logic [3:0] r0_nrd,
  input  logic [7:0] r0_wdata,
  input  logic       r1_req,
  input  logic [7:0] r1_op,
  input  logic [3:0] r1_nwr,
  input  logic [3:0] r1_nrd,
  input  logic [7:0] r1_wdata,
  output logic [1:0] gnt,
  output logic       wdata_take,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       done,
  output logic       eng_wr_valid,
  output logic [7:0] eng_wr_data,
  output logic       eng_rd_stop,
  input  logic       eng_wr_got_byte,
  input  logic       eng_wr_done,
  input  logic       eng_rd_valid,
  input  logic [7:0] eng_rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_WR, S_RD, S_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     r_state, w_state;
  logic [1:0] r_gnt, w_gnt;
  logic       r_last, w_last;       // 1: requester 1 was served last
  logic [7:0] r_op, w_op;
  logic [3:0] r_nwr, w_nwr;
  logic [3:0] r_nrd, w_nrd;
  logic [3:0] r_cnt, w_cnt;         // bytes remaining in the current phase
  logic [3:0] r_gap, w_gap;
  logic       r_sent, w_sent;       // byte accepted, waiting for eng_wr_done
  logic       r_wr_valid, w_wr_valid;
  logic       r_take, w_take;
  logic [7:0] r_rdata, w_rdata;
  logic       r_rvld, w_rvld;
  logic       r_done, w_done;
  logic       r_rd_stop, w_rd_stop;
  logic       w_pick1;
  logic [7:0] w_wdata;

  // With both requesting, serve whoever was not served last.
  assign w_pick1 = r1_req & (~r0_req | ~r_last);
  assign w_wdata = r_gnt[1] ? r1_wdata : r0_wdata;

  assign gnt          = r_gnt;
  assign wdata_take   = r_take;
  assign rdata        = r_rdata;
  assign rdata_valid  = r_rvld;
  assign done         = r_done;
  assign eng_wr_valid = r_wr_valid;
  // Payload bytes pass straight through so a byte refreshed after wdata_take is what the engine sees.
  assign eng_wr_data  = (r_state == S_WR) ? w_wdata : r_op;
  assign eng_rd_stop  = r_rd_stop;

  // Register all state and outputs; reset parks the engine with reads stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_last     <= 1'b1;
      r_op       <= 8'h00;
      r_nwr      <= 4'd0;
      r_nrd      <= 4'd0;
      r_cnt      <= 4'd0;
      r_gap      <= 4'd0;
      r_sent     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_take     <= 1'b0;
      r_rdata    <= 8'h00;
      r_rvld     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_stop  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_gnt      <= w_gnt;
      r_last     <= w_last;
      r_op       <= w_op;
      r_nwr      <= w_nwr;
      r_nrd      <= w_nrd;
      r_cnt      <= w_cnt;
      r_gap      <= w_gap;
      r_sent     <= w_sent;
      r_wr_valid <= w_wr_valid;
      r_take     <= w_take;
      r_rdata    <= w_rdata;
      r_rvld     <= w_rvld;
      r_done     <= w_done;
      r_rd_stop  <= w_rd_stop;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    w_state    = r_state;
    w_gnt      = r_gnt;
    w_last     = r_last;
    w_op       = r_op;
    w_nwr      = r_nwr;
    w_nrd      = r_nrd;
    w_cnt      = r_cnt;
    w_gap      = r_gap;
    w_sent     = r_sent;
    w_wr_valid = r_wr_valid;
    w_take     = 1'b0;
    w_rdata    = r_rdata;
    w_rvld     = 1'b0;
    w_done     = 1'b0;
    w_rd_stop  = r_rd_stop;
    case (r_state)
      S_IDLE: begin
        if (r0_req | r1_req) begin
          w_gnt      = w_pick1 ? 2'b10 : 2'b01;
          w_op       = w_pick1 ? r1_op : r0_op;
          w_nwr      = w_pick1 ? r1_nwr : r0_nwr;
          w_nrd      = w_pick1 ? r1_nrd : r0_nrd;
          w_sent     = 1'b0;
          w_wr_valid = 1'b1;
          w_state    = S_OP;
        end
      end
      S_OP: begin
        if (!r_sent) begin
          if (eng_wr_got_byte) begin
            w_wr_valid = 1'b0;
            w_sent     = 1'b1;
          end
        end else if (eng_wr_done) begin
          w_sent = 1'b0;
          if (r_nwr != 4'd0) begin
            w_state    = S_WR;
            w_cnt      = r_nwr;
            w_wr_valid = 1'b1;
          end else if (r_nrd != 4'd0) begin
            w_state   = S_RD;
            w_cnt     = r_nrd;
            w_rd_stop = 1'b0;
          end else begin
            w_state = S_GAP;
            w_gap   = GAP_LAST;
          end
        end
      end
      S_WR: begin
        if (!r_sent) begin
          if (eng_wr_got_byte) begin
            w_wr_valid = 1'b0;
            w_take     = 1'b1;
            w_sent     = 1'b1;
          end
        end else if (eng_wr_done) begin
          w_sent = 1'b0;
          w_cnt  = r_cnt - 4'd1;
          if (r_cnt != 4'd1) begin
            w_wr_valid = 1'b1;
          end else if (r_nrd != 4'd0) begin
            w_state   = S_RD;
            w_cnt     = r_nrd;
            w_rd_stop = 1'b0;
          end else begin
            w_state = S_GAP;
            w_gap   = GAP_LAST;
          end
        end
      end
      S_RD: begin
        if (eng_rd_valid) begin
          w_rdata = eng_rd_data;
          w_rvld  = 1'b1;
          w_cnt   = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_rd_stop = 1'b1;
            w_state   = S_GAP;
            w_gap     = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        if (r_gap == 4'd0) begin
          w_done  = 1'b1;
          w_gnt   = 2'b00;
          w_last  = r_gnt[1];
          w_state = S_IDLE;
        end else begin
          w_gap = r_gap - 4'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmod_nic100_spi_arbiter.sv
// Directed bench for pmod_nic100_spi_arbiter; the bench plays both requesters and the byte engine.
// Inputs are driven and outputs sampled on the falling clock edge.
// Engine accepts each write byte one cycle after valid and reports done one cycle later.
module tb_pmod_nic100_spi_arbiter;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req, r1_req;
  logic [7:0] r0_op, r1_op, r0_wdata, r1_wdata;
  logic [3:0] r0_nwr, r1_nwr, r0_nrd, r1_nrd;
  logic [1:0] gnt;
  logic       wdata_take, rdata_valid, done, eng_wr_valid, eng_rd_stop;
  logic [7:0] rdata, eng_wr_data;
  logic       eng_wr_got_byte, eng_wr_done, eng_rd_valid;
  logic [7:0] eng_rd_data;

  int total = 0;
  int bad   = 0;
  int done_cnt, take_cnt, rvld_cnt;
  logic [1:0] gnt_or;
  logic [7:0] wq0 [4];
  logic [7:0] wq1 [4];
  int idx0, idx1;

  pmod_nic100_spi_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_op(r0_op), .r0_nwr(r0_nwr), .r0_nrd(r0_nrd), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_op(r1_op), .r1_nwr(r1_nwr), .r1_nrd(r1_nrd), .r1_wdata(r1_wdata),
    .gnt(gnt), .wdata_take(wdata_take), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .eng_wr_valid(eng_wr_valid), .eng_wr_data(eng_wr_data), .eng_rd_stop(eng_rd_stop),
    .eng_wr_got_byte(eng_wr_got_byte), .eng_wr_done(eng_wr_done),
    .eng_rd_valid(eng_rd_valid), .eng_rd_data(eng_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then log events and act as the requester's wdata source.
  task automatic step();
    @(negedge clk);
    gnt_or = gnt_or | gnt;
    if (done) done_cnt++;
    if (rdata_valid) rvld_cnt++;
    if (wdata_take) begin
      take_cnt++;
      if (gnt[1]) begin
        idx1 = (idx1 + 1) & 3;
        r1_wdata = wq1[idx1];
      end else begin
        idx0 = (idx0 + 1) & 3;
        r0_wdata = wq0[idx0];
      end
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0; take_cnt = 0; rvld_cnt = 0; gnt_or = 2'b00;
  endtask

  // Engine write handshake: wait for valid, accept, then report done a cycle later.
  task automatic eng_write(output logic [7:0] b);
    int n = 0;
    while (eng_wr_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wr_valid_seen", {31'd0, eng_wr_valid}, 32'd1);
    b = eng_wr_data;
    eng_wr_got_byte = 1'b1;
    step();
    eng_wr_got_byte = 1'b0;
    chk("wr_valid_drop", {31'd0, eng_wr_valid}, 32'd0);
    step();
    chk("wr_valid_wait_done", {31'd0, eng_wr_valid}, 32'd0);
    eng_wr_done = 1'b1;
    step();
    eng_wr_done = 1'b0;
  endtask

  task automatic eng_read(input logic [7:0] d, input logic stop_exp);
    eng_rd_valid = 1'b1;
    eng_rd_data  = d;
    step();
    eng_rd_valid = 1'b0;
    chk("rdata_valid", {31'd0, rdata_valid}, 32'd1);
    chk("rdata", {24'd0, rdata}, {24'd0, d});
    chk("rd_stop", {31'd0, eng_rd_stop}, {31'd0, stop_exp});
  endtask

  // Returns at the falling edge where done is seen; cycles counts steps taken.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("gnt_clear_at_done", {30'd0, gnt}, 32'd0);
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt === 2'b00 && n < 10) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [7:0] b;
    int cyc;
    logic [1:0] exp_g [3];
    logic [7:0] exp_op [3];
    exp_g  = '{2'b01, 2'b10, 2'b01};
    exp_op = '{8'h30, 8'h31, 8'h30};
    wq0 = '{8'hAA, 8'h55, 8'h00, 8'h00};
    wq1 = '{8'h00, 8'h00, 8'h00, 8'h00};
    idx0 = 0; idx1 = 0;
    rst = 1'b1;
    r0_req = 0; r0_op = 0; r0_nwr = 0; r0_nrd = 0; r0_wdata = wq0[0];
    r1_req = 0; r1_op = 0; r1_nwr = 0; r1_nrd = 0; r1_wdata = wq1[0];
    eng_wr_got_byte = 0; eng_wr_done = 0; eng_rd_valid = 0; eng_rd_data = 0;
    clear_stats();
    step();
    step();
    // Reset state
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_rd_stop", {31'd0, eng_rd_stop}, 32'd1);
    chk("rst_wr_valid", {31'd0, eng_wr_valid}, 32'd0);
    chk("rst_wr_data", {24'd0, eng_wr_data}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rvld_done_take", {29'd0, rdata_valid, done, wdata_take}, 32'd0);
    rst = 1'b0;
    step();

    // r0: opcode 0x20 then two payload bytes
    clear_stats();
    r0_req = 1; r0_op = 8'h20; r0_nwr = 4'd2; r0_nrd = 4'd0;
    eng_write(b); chk("t1_op", {24'd0, b}, 32'h20);
    eng_write(b); chk("t1_wr0", {24'd0, b}, 32'hAA);
    eng_write(b); chk("t1_wr1", {24'd0, b}, 32'h55);
    wait_done(cyc);
    r0_req = 0;
    chk("t1_gap", cyc, GAP);
    step(); step(); step();
    chk("t1_takes", take_cnt, 2);
    chk("t1_dones", done_cnt, 1);
    chk("t1_gnt_or", {30'd0, gnt_or}, 32'd1);

    // r1: opcode 0x22 then three read bytes
    clear_stats();
    r1_req = 1; r1_op = 8'h22; r1_nwr = 4'd0; r1_nrd = 4'd3;
    eng_write(b); chk("t2_op", {24'd0, b}, 32'h22);
    chk("t2_rd_stop_low", {31'd0, eng_rd_stop}, 32'd0);
    eng_read(8'h11, 1'b0);
    eng_read(8'h22, 1'b0);
    eng_read(8'h33, 1'b1);
    wait_done(cyc);
    r1_req = 0;
    chk("t2_gap", cyc, GAP);
    step(); step();
    chk("t2_rvld", rvld_cnt, 3);
    chk("t2_gnt_or", {30'd0, gnt_or}, 32'd2);

    // r0: opcode only
    clear_stats();
    r0_req = 1; r0_op = 8'h05; r0_nwr = 4'd0; r0_nrd = 4'd0;
    eng_write(b); chk("t3_op", {24'd0, b}, 32'h05);
    wait_done(cyc);
    r0_req = 0;
    chk("t3_gap", cyc, GAP);
    step(); step();
    chk("t3_takes", take_cnt, 0);
    chk("t3_rvld", rvld_cnt, 0);
    chk("t3_dones", done_cnt, 1);

    // r1 read transaction interrupted by reset on the second byte
    clear_stats();
    r1_req = 1; r1_op = 8'h0B; r1_nwr = 4'd0; r1_nrd = 4'd3;
    eng_write(b); chk("t4_op", {24'd0, b}, 32'h0B);
    eng_read(8'h44, 1'b0);
    eng_rd_valid = 1'b1; eng_rd_data = 8'h55;
    rst = 1'b1;
    #1;
    chk("t4_async_rd_stop", {31'd0, eng_rd_stop}, 32'd1);
    chk("t4_async_gnt", {30'd0, gnt}, 32'd0);
    chk("t4_async_rvld", {31'd0, rdata_valid}, 32'd0);
    eng_rd_valid = 1'b0;
    r1_req = 0;
    step();
    rst = 1'b0;
    step(); step(); step(); step();
    chk("t4_no_done", done_cnt, 0);

    // Both requesting for three transactions: pointer reset favours r0
    clear_stats();
    r0_req = 1; r0_op = 8'h30; r0_nwr = 4'd0; r0_nrd = 4'd0;
    r1_req = 1; r1_op = 8'h31; r1_nwr = 4'd0; r1_nrd = 4'd0;
    for (int t = 0; t < 3; t++) begin
      wait_gnt();
      chk("t5_gnt", {30'd0, gnt}, {30'd0, exp_g[t]});
      eng_write(b);
      chk("t5_op", {24'd0, b}, {24'd0, exp_op[t]});
      wait_done(cyc);
      chk("t5_gap", cyc, GAP);
      if (t == 2) begin
        r0_req = 0;
        r1_req = 0;
      end
    end
    step(); step();
    chk("t5_dones", done_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmod_nic100_spi_arbiter.md
PMOD_NIC100_SPI_ARBITER -- requirements
Module: pmod_nic100_spi_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles inserted after each transaction before the next grant (range 1..15).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have ports r0_req / r1_req  input  1  transaction request, held high until done.
REQ-006 The block SHALL have ports r0_op / r1_op  input  8  opcode byte.
REQ-007 The block SHALL have ports r0_nwr / r1_nwr  input  4  payload bytes to write after opcode (0..15).
REQ-008 The block SHALL have ports r0_nrd / r1_nrd  input  4  bytes to read after writes (0..15).
REQ-009 The block SHALL have ports r0_wdata / r1_wdata  input  8  current payload byte.
REQ-010 The block SHALL have port gnt  output  2  one-hot grant, bit n = requester n.
REQ-011 The block SHALL have port wdata_take  output  1  1-cycle pulse: granted requester's wdata consumed, present next byte.
REQ-012 The block SHALL have ports rdata  output  8 and rdata_valid  output  1  read byte and 1-cycle qualifier for granted requester.
REQ-013 The block SHALL have port done  output  1  1-cycle pulse at transaction end.
REQ-014 The block SHALL have ports eng_wr_valid  output  1, eng_wr_data  output  8, eng_rd_stop  output  1  byte-engine controls.
REQ-015 The block SHALL have ports eng_wr_got_byte  input  1, eng_wr_done  input  1, eng_rd_valid  input  1, eng_rd_data  input  8  byte-engine status.

Function
REQ-016 The FSM SHALL have states IDLE, OP, WR, RD, GAP.
REQ-017 In IDLE with any req high, the block SHALL grant one requester, latching its op, nwr, nrd, and SHALL enter OP next cycle with gnt set.
REQ-018 Arbitration SHALL be round-robin: both requesting -> grant the one not served last; single requester -> grant it; after reset requester 0 wins a tie.
REQ-019 OP: eng_wr_valid=1, eng_wr_data=latched op until eng_wr_got_byte; eng_wr_valid SHALL drop the cycle after got_byte; wait eng_wr_done, then go to WR (nwr>0), else RD (nrd>0), else GAP.
REQ-020 WR: per byte, drive eng_wr_data=granted wdata with eng_wr_valid=1 until got_byte; on got_byte pulse wdata_take once; wait eng_wr_done; after nwr bytes go to RD (nrd>0) else GAP.
REQ-021 eng_wr_valid SHALL never be high while waiting for eng_wr_done (no duplicate byte).
REQ-022 RD: eng_rd_stop=0; each eng_rd_valid SHALL produce rdata=eng_rd_data, rdata_valid=1 next cycle; on the nrd-th byte eng_rd_stop SHALL go 1 same registered edge as rdata_valid; then GAP.
REQ-023 eng_rd_valid outside RD SHALL be ignored; eng_wr_got_byte/eng_wr_done outside OP/WR SHALL be ignored.
REQ-024 GAP: count GAP_CYCLES cycles; on the final cycle pulse done, clear gnt, update round-robin pointer, return to IDLE; no grant in the done cycle.
REQ-025 Requester inputs other than wdata SHALL be sampled only at grant; req deassert mid-transaction SHALL NOT abort it.
REQ-026 Byte counters SHALL be 4-bit; nwr=0 or nrd=0 SHALL skip the phase with no engine activity.

Reset
REQ-027 While rst=1 (asynchronous): state=IDLE, gnt=0, wdata_take=0, rdata=0, rdata_valid=0, done=0, eng_wr_valid=0, eng_wr_data=0, eng_rd_stop=1, counters=0, pointer favours requester 0.
REQ-028 rst asserted mid-transaction SHALL immediately force REQ-027 values; the transaction is discarded with no done pulse.

Verification
REQ-029 r0 op=0x20, nwr=2, nrd=0, wdata 0xAA then 0x55 -> engine sees 0x20,0xAA,0x55; two wdata_take; one done; gnt=01 throughout.
REQ-030 r1 op=0x22, nwr=0, nrd=3, engine returns 0x11,0x22,0x33 -> three rdata_valid with those values; eng_rd_stop=1 after third; done.
REQ-031 r0 and r1 requesting together, held for 3 transactions -> grants 01,10,01; GAP_CYCLES idle cycles between each.
REQ-032 nwr=0, nrd=0 -> opcode only, then done after GAP_CYCLES; wdata_take, rdata_valid never high.
REQ-033 rst pulsed during RD byte 2 -> eng_rd_stop=1, gnt=0 asynchronously; no done; next request granted normally, requester 0 wins a tie.
